// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, ALU
// operation codes, opcodes, datapath mux selects and the per-state control word.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWRITE = 4'd4,
    S_MEMWB    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // fetch marks the state whose PC/IR enables are qualified by MemReady.
  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       fetch;
    logic       pc_update;
    logic       branch;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURESULT;
        c.fetch      = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: c.adr_src = 1'b1;
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
      end
      S_EXECUTER: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: c.reg_write = 1'b1;
      S_BEQ: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_op    = ALUOP_SUB;
        c.branch    = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_FOUR;
        c.pc_update = 1'b1;
      end
      S_TRAP: c.illegal = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALUOp/funct decode producing the ALUControl code consumed by alu.
module alu_decoder
  import cpu_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // op5 separates R-type sub from addi, whose imm may set bit 30.
          3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b100:  alu_control_o = ALU_XOR;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the multicycle RV32I datapath: state register, next-state
// logic, registered per-state control word and the ImmSrc decode.
module multicycle_control
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       Illegal,
  output logic [3:0] dbg_state_o
);

  state_t state_q, state_d;
  ctrl_t  ctrl_q;

  // MemReady acts as the memory's ready: a FETCH, MEMREAD or MEMWRITE access
  // completes (and the state advances) only on a cycle where it is high.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_ITYPE:     state_d = S_EXECUTEI;
          OP_BRANCH:    state_d = (funct3 == 3'b000) ? S_BEQ : S_TRAP;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWRITE: if (MemReady) state_d = S_FETCH;
      S_MEMWB:    state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
  end

  // The control word is registered alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ctrl_q  <= ctrl_for(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_for(state_d);
    end
  end

  alu_decoder u_alu_decoder (
    .alu_op_i      (ctrl_q.alu_op),
    .funct3_i      (funct3),
    .op5_i         (op[5]),
    .funct7b5_i    (funct7b5),
    .alu_control_o (ALUControl)
  );

  always_comb begin
    case (op)
      OP_LW, OP_ITYPE: ImmSrc = IMM_I;
      OP_SW:           ImmSrc = IMM_S;
      OP_BRANCH:       ImmSrc = IMM_B;
      OP_JAL:          ImmSrc = IMM_J;
      default:         ImmSrc = IMM_I;
    endcase
  end

  // Write enables are masked while reset is held so an abandoned instruction
  // never commits on the reset edge.
  assign PCWrite   = rst_n & ((ctrl_q.fetch & MemReady) | ctrl_q.pc_update
                              | (ctrl_q.branch & zero));
  assign IRWrite   = rst_n & ctrl_q.fetch & MemReady;
  assign MemWrite  = rst_n & ctrl_q.mem_write;
  assign RegWrite  = rst_n & ctrl_q.reg_write;
  assign AdrSrc    = ctrl_q.adr_src;
  assign ResultSrc = ctrl_q.result_src;
  assign ALUSrcA   = ctrl_q.alu_src_a;
  assign ALUSrcB   = ctrl_q.alu_src_b;
  assign Illegal   = ctrl_q.illegal;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: an instruction-level model expands each
// instruction into its expected per-cycle control outputs.
module tb_multicycle_control;

  localparam int W = 17;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] cur_op = 7'b0110011;
  logic [2:0] cur_f3 = 3'b000;
  logic       cur_f7 = 1'b0;
  logic       zero = 1'b0;
  logic       MemReady = 1'b1;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] dbg_state;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (cur_op),
    .funct3     (cur_f3),
    .funct7b5   (cur_f7),
    .zero       (zero),
    .MemReady   (MemReady),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .Illegal    (Illegal),
    .dbg_state_o(dbg_state)
  );

  typedef struct packed {
    logic rst;
    logic mr;
    logic z;
  } stim_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    int         fw;
    int         mw;
    logic       z;
    int         exp_len;
  } vec_t;

  stim_t          stim_q[$];
  logic [W-1:0]   exp_q[$];
  int             vectors = 0;
  int             miscompares = 0;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] ref_imm(input logic [6:0] o);
    case (o)
      7'b0000011, 7'b0010011: return 2'b00;
      7'b0100011:             return 2'b01;
      7'b1100011:             return 2'b10;
      7'b1101111:             return 2'b11;
      default:                return 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] ref_alu(input logic [2:0] f3, input logic op5, input logic f7);
    case (f3)
      3'b000:  return (op5 && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b100:  return 3'b100;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // One expected cycle: inputs to drive, outputs the DUT must show.
  task automatic push(input logic rst, input logic mr, input logic z,
                      input logic pcw, input logic adr, input logic mw,
                      input logic irw, input logic rw, input logic [1:0] rs,
                      input logic [1:0] sa, input logic [1:0] sb,
                      input logic [2:0] aluc, input logic ill);
    stim_t s;
    s.rst = rst;
    s.mr  = mr;
    s.z   = z;
    if (!rst) begin
      pcw = 1'b0;
      mw  = 1'b0;
      irw = 1'b0;
      rw  = 1'b0;
    end
    stim_q.push_back(s);
    exp_q.push_back({pcw, adr, mw, irw, rw, rs, sa, sb, ref_imm(cur_op), aluc, ill});
  endtask

  task automatic push_fetch_wait(input logic rst);
    push(rst, 1'b0, rb(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0);
  endtask

  task automatic gen_fetch(input int fw);
    for (int k = 0; k < fw; k++) push_fetch_wait(1'b1);
    push(1'b1, 1'b1, rb(), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0);
  endtask

  task automatic gen_decode();
    push(1'b1, rb(), rb(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 1'b0);
  endtask

  task automatic gen_aluwb();
    push(1'b1, rb(), rb(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
  endtask

  // Whole legal instruction, then one trailing fetch-wait cycle of the next.
  task automatic gen_instr(input int fw, input int mw, input logic z);
    logic is_sw;
    is_sw = (cur_op == 7'b0100011);
    gen_fetch(fw);
    gen_decode();
    if (cur_op == 7'b0000011 || is_sw) begin
      push(1'b1, rb(), rb(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0);
      for (int k = 0; k < mw; k++)
        push(1'b1, 1'b0, rb(), 1'b0, 1'b1, is_sw, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
      push(1'b1, 1'b1, rb(), 1'b0, 1'b1, is_sw, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
      if (!is_sw)
        push(1'b1, rb(), rb(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0);
    end else if (cur_op == 7'b0110011 || cur_op == 7'b0010011) begin
      push(1'b1, rb(), rb(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10,
           (cur_op == 7'b0010011) ? 2'b01 : 2'b00, ref_alu(cur_f3, cur_op[5], cur_f7), 1'b0);
      gen_aluwb();
    end else if (cur_op == 7'b1100011) begin
      push(1'b1, rb(), z, z, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 1'b0);
    end else begin
      push(1'b1, rb(), rb(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 1'b0);
      gen_aluwb();
    end
    push_fetch_wait(1'b1);
  endtask

  task automatic gen_trap_cycle(input logic rst);
    push(rst, rb(), rb(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1);
  endtask

  // Drives and checks every queued cycle; len = cycles from the first fetch
  // cycle until the DUT is observed back in fetch after committing one.
  task automatic apply_q(output int len);
    stim_t        s;
    logic [W-1:0] e, got;
    bit           committed;
    int           i;
    len = -1;
    committed = 0;
    i = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(posedge clk);
      #1;
      rst_n = s.rst;
      MemReady = s.mr;
      zero = s.z;
      @(negedge clk);
      got = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
             ALUSrcB, ImmSrc, ALUControl, Illegal};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL ctrl vec %0d cyc %0d op %b: got %b expected %b (pcw adr mw irw rw rs sa sb imm aluc ill)",
                 vectors, i, cur_op, got, e);
      end
      if (committed && len < 0 && ALUSrcA == 2'b00 && ALUSrcB == 2'b10 && ResultSrc == 2'b10)
        len = i;
      if (IRWrite === 1'b1) committed = 1;
      i++;
    end
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    cur_op = o;
    cur_f3 = f3;
    cur_f7 = f7;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[13];
    int   len;
    logic [6:0] ops[6];

    tbl[0]  = '{7'b0110011, 3'b000, 1'b0, 0, 0, 1'b0, 4};  // add
    tbl[1]  = '{7'b0110011, 3'b000, 1'b1, 1, 0, 1'b0, 5};  // sub, one fetch wait
    tbl[2]  = '{7'b0010011, 3'b010, 1'b0, 0, 0, 1'b0, 4};  // slti
    tbl[3]  = '{7'b0010011, 3'b000, 1'b1, 0, 0, 1'b0, 4};  // addi with bit30 set
    tbl[4]  = '{7'b0000011, 3'b010, 1'b0, 0, 2, 1'b0, 7};  // lw, two read waits
    tbl[5]  = '{7'b0100011, 3'b010, 1'b0, 0, 1, 1'b0, 5};  // sw, one write wait
    tbl[6]  = '{7'b1100011, 3'b000, 1'b0, 0, 0, 1'b1, 3};  // beq taken
    tbl[7]  = '{7'b1100011, 3'b000, 1'b0, 2, 0, 1'b0, 5};  // beq not taken
    tbl[8]  = '{7'b1101111, 3'b000, 1'b0, 0, 0, 1'b0, 4};  // jal
    tbl[9]  = '{7'b0110011, 3'b111, 1'b0, 0, 0, 1'b0, 4};  // and
    tbl[10] = '{7'b0010011, 3'b110, 1'b1, 0, 3, 1'b0, 4};  // ori
    tbl[11] = '{7'b0110011, 3'b001, 1'b1, 0, 0, 1'b0, 4};  // sll decodes to add
    tbl[12] = '{7'b0110011, 3'b100, 1'b0, 0, 0, 1'b0, 4};  // xor

    // Reset: FETCH selects with enables masked even though MemReady is high.
    set_instr(7'b0110011, 3'b000, 1'b0);
    push(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0);
    push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0);
    push_fetch_wait(1'b1);
    apply_q(len);

    for (int t = 0; t < 13; t++) begin
      set_instr(tbl[t].op, tbl[t].f3, tbl[t].f7);
      gen_instr(tbl[t].fw, tbl[t].mw, tbl[t].z);
      apply_q(len);
      vectors++;
      if (len != tbl[t].exp_len) begin
        miscompares++;
        $display("FAIL latency entry %0d op %b: got %0d cycles expected %0d", t, tbl[t].op, len, tbl[t].exp_len);
      end
    end

    // Unknown opcode traps and stays trapped until a reset edge.
    set_instr(7'b1111111, 3'b000, 1'b0);
    gen_fetch(0);
    gen_decode();
    for (int k = 0; k < 12; k++) gen_trap_cycle(1'b1);
    gen_trap_cycle(1'b0);
    push_fetch_wait(1'b1);
    apply_q(len);

    // beq with funct3 != 000 is also illegal.
    set_instr(7'b1100011, 3'b001, 1'b0);
    gen_fetch(0);
    gen_decode();
    gen_trap_cycle(1'b1);
    gen_trap_cycle(1'b1);
    gen_trap_cycle(1'b0);
    push_fetch_wait(1'b1);
    apply_q(len);

    // Reset during EXECUTEI abandons the write-back.
    set_instr(7'b0010011, 3'b100, 1'b0);
    gen_fetch(0);
    gen_decode();
    push(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b01, 3'b100, 1'b0);
    push_fetch_wait(1'b1);
    apply_q(len);

    // Reset during a MEMREAD wait, then during FETCH with MemReady high.
    set_instr(7'b0000011, 3'b010, 1'b0);
    gen_fetch(1);
    gen_decode();
    push(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0);
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
    push(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0);
    push_fetch_wait(1'b1);
    apply_q(len);

    ops[0] = 7'b0000011;
    ops[1] = 7'b0100011;
    ops[2] = 7'b0110011;
    ops[3] = 7'b0010011;
    ops[4] = 7'b1100011;
    ops[5] = 7'b1101111;
    for (int n = 0; n < 80; n++) begin
      int k;
      k = int'($urandom_range(0, 5));
      set_instr(ops[k], (k == 4) ? 3'b000 : 3'($urandom_range(0, 7)), rb());
      gen_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), rb());
      apply_q(len);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Control unit for the multicycle RV32I datapath, sitting directly upstream of `alu`. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives every datapath enable and mux select. It also derives the 3-bit `ALUControl` that `alu` consumes from the opcode and funct fields, and it uses `alu`'s `zero` output to resolve `beq`.

## Interface
Parameters: none.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `op` in 7: instruction bits [6:0].
- `funct3` in 3: instruction bits [14:12].
- `funct7b5` in 1: instruction bit 30.
- `zero` in 1: from `alu`; high when `ALUResult` is zero.
- `MemReady` in 1: memory completes the current access this cycle.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select; 0 = PC, 1 = Result.
- `MemWrite` out 1: memory write strobe.
- `IRWrite` out 1: instruction register and OldPC enable.
- `RegWrite` out 1: register file write enable.
- `ResultSrc` out 2: Result select; 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` out 2: SrcA select; 00 = PC, 01 = OldPC, 10 = RD1.
- `ALUSrcB` out 2: SrcB select; 00 = RD2, 01 = ImmExt, 10 = constant 4.
- `ImmSrc` out 2: immediate format; 00 = I, 01 = S, 10 = B, 11 = J.
- `ALUControl` out 3: operation code to `alu`.
- `Illegal` out 1: high while the unit is in TRAP.

## Operation
**ALUControl encoding:** 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.

**ALUOp (internal, 2 bits)** maps to `ALUControl` as follows:
- 00 → add.
- 01 → sub.
- 10 → decoded from `funct3`:
  - 000: sub if `op[5]` and `funct7b5` are both 1, otherwise add.
  - 010: slt.
  - 100: xor.
  - 110: or.
  - 111: and.
  - Any other `funct3`: add.

**ImmSrc** is a pure function of `op`: lw and ALU-I → 00, sw → 01, beq → 10, jal → 11, otherwise 00.

**Moore state machine.** Any output not listed for a state is 0. Outputs per state, then transitions:
- **FETCH:** AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, IRWrite=MemReady, PCUpdate=MemReady. Goes to DECODE when `MemReady`, otherwise stays in FETCH.
- **DECODE:** ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch/jump target). Next state by `op`:
  - 0000011 or 0100011 → MEMADR.
  - 0110011 → EXECUTER.
  - 0010011 → EXECUTEI.
  - 1100011 with `funct3`=000 → BEQ.
  - 1101111 → JAL.
  - Anything else → TRAP.
- **MEMADR:** ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD for lw, MEMWRITE for sw.
- **MEMREAD:** AdrSrc=1, ResultSrc=00. Goes to MEMWB when `MemReady`, otherwise stays.
- **MEMWRITE:** AdrSrc=1, ResultSrc=00, MemWrite=1. `MemWrite` is held for every cycle of the state. Goes to FETCH when `MemReady`, otherwise stays.
- **MEMWB:** ResultSrc=01, RegWrite=1. Goes to FETCH.
- **EXECUTER:** ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- **EXECUTEI:** ALUSrcA=10, ALUSrcB=01, ALUOp=10. Goes to ALUWB.
- **ALUWB:** ResultSrc=00, RegWrite=1. Goes to FETCH.
- **BEQ:** ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Goes to FETCH.
- **JAL:** ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Goes to ALUWB.
- **TRAP:** all enables 0, Illegal=1. Absorbing; only reset leaves it.

**PC enable:** `PCWrite` = PCUpdate OR (Branch AND `zero`).

## Timing
**Reset:**
- While `rst_n`=0, `PCWrite`, `IRWrite`, `MemWrite` and `RegWrite` are forced to 0 combinationally.
- The first rising edge with `rst_n`=0 loads FETCH.
- After reset, `Illegal`=0 and the mux selects take their FETCH values.
- Reset asserted mid-instruction (including during a wait state or in TRAP) abandons the instruction; no write enable is asserted on that edge.

**Latency with zero wait states (`MemReady` held 1):**
- lw: 5 cycles.
- sw, R-type, I-type ALU, jal: 4 cycles.
- beq: 3 cycles.

Each cycle `MemReady` is low in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.

**Output timing:**
- `zero` is sampled combinationally in BEQ only. The branch decision and `PCWrite` occur in the same cycle.
- `IRWrite` and the PC update in FETCH occur only on the cycle `MemReady` is high, so each fetch commits exactly once.
- `ALUControl` is valid in every state; it is don't-care to the datapath outside ALU-using states.

## Structure
**Shared package `cpu_pkg`:**
- State encoding (4-bit, 12 states).
- ALUControl codes.
- Opcode constants.
- ALUSrcA/ALUSrcB/ResultSrc/ImmSrc encodings.

`alu` imports the ALUControl codes from `cpu_pkg`.

**Sub-module `alu_decoder`** (combinational): maps ALUOp, `funct3`, `op[5]` and `funct7b5` to `ALUControl`.

The top level holds the state register, next-state logic, output decode and the `ImmSrc` decode.

## Test plan
- **add x3,x1,x2** (op=0110011, funct3=000, funct7b5=0), `MemReady`=1 → states FETCH, DECODE, EXECUTER, ALUWB; `ALUControl`=000 in EXECUTER; `RegWrite`=1 only in cycle 4.
- **lw** (op=0000011), `MemReady` low for 2 cycles in MEMREAD → 7-cycle instruction; `RegWrite`=1 exactly once, in MEMWB with `ResultSrc`=01.
- **sw** (op=0100011), `MemReady` low for 1 cycle in MEMWRITE → `MemWrite`=1 for 2 consecutive cycles, then FETCH; `RegWrite` never asserted.
- **beq** (op=1100011, funct3=000) → `ALUControl`=001 in BEQ; `PCWrite`=1 with `zero`=1, `PCWrite`=0 with `zero`=0; back in FETCH at cycle 4.
- **op=1111111** → TRAP after DECODE; `Illegal`=1 and all enables 0 for 10+ cycles; `rst_n`=0 for one edge → FETCH and `Illegal`=0.
- **rst_n dropped during EXECUTEI** (op=0010011) → no `RegWrite`; FETCH on the next edge; `PCWrite`/`IRWrite` are 0 while `rst_n`=0.
